// File: rtl/sys_mem_responder.sv
// sys_mem_responder: system-bus target that models main memory behind the
// data cache. Accepts one word request in IDLE, spends WAIT_CYCLES cycles in
// WAIT, one cycle in RESP, and pulses SysReady on the edge leaving RESP.
// Reads are sampled into SysRData on the edge entering RESP. Byte-enabled
// writes commit on the edge leaving RESP.
// Optional feature macro: SYS_RESP_ERR_EN (adds SysErr and range checking;
// without it, addresses wrap modulo DEPTH).
module sys_mem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned AW          = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SysStrobe,
  input  logic        SysRW,
  input  logic [31:0] SysAddr,
  input  logic [31:0] SysWData,
  input  logic [3:0]  SysByteEn,
  output logic [31:0] SysRData,
  output logic        SysReady,
`ifdef SYS_RESP_ERR_EN
  output logic        SysErr,
`endif
  output logic        SysBusy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [3:0]      count_reg, count_next;
  logic            rw_reg;
  logic [AW-1:0]   idx_reg;
  logic [31:0]     wdata_reg;
  logic [3:0]      be_reg;
  logic            err_reg;
  logic            ready_reg;
  logic [31:0]     rdata_reg;
`ifdef SYS_RESP_ERR_EN
  logic            err_out_reg;
`endif

  logic            accept;
  logic            rw_now;
  logic            oor_now;
  logic [AW-1:0]   idx_now;
  logic            load_rdata;
  logic            do_write;
  logic [31:0]     rd_word;
  logic            unused_bits;

  // Request fields come straight from the bus on the accept edge (needed when
  // WAIT_CYCLES = 0 and RESP is entered on that same edge), else from latches.
  assign accept  = (state_reg == IDLE) && SysStrobe;
  assign rw_now  = accept ? SysRW : rw_reg;
  assign idx_now = accept ? SysAddr[AW+1:2] : idx_reg;
`ifdef SYS_RESP_ERR_EN
  assign oor_now = accept ? (|SysAddr[31:AW+2]) : err_reg;
`else
  assign oor_now = 1'b0;
`endif

  // Only the word index is decoded; the low byte offset never matters.
  assign unused_bits = ^{SysAddr[31:AW+2], SysAddr[1:0]};

  assign load_rdata = (state_next == RESP) && (state_reg != RESP) && rw_now;
  // rst in the enable keeps an aborted request from committing.
  assign do_write   = (state_reg == RESP) && !rw_reg && !err_reg && rst;

  // Next-state and wait-counter decode.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (SysStrobe) begin
          count_next = 4'(WAIT_CYCLES);
          state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        count_next = count_reg - 4'd1;
        if (count_reg == 4'd1) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control state, request latches, and registered bus outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      count_reg   <= 4'd0;
      rw_reg      <= 1'b0;
      idx_reg     <= '0;
      wdata_reg   <= 32'd0;
      be_reg      <= 4'd0;
      err_reg     <= 1'b0;
      ready_reg   <= 1'b0;
      rdata_reg   <= 32'd0;
`ifdef SYS_RESP_ERR_EN
      err_out_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      ready_reg <= (state_reg == RESP);
`ifdef SYS_RESP_ERR_EN
      err_out_reg <= (state_reg == RESP) && err_reg;
`endif
      if (accept) begin
        rw_reg    <= SysRW;
        idx_reg   <= SysAddr[AW+1:2];
        wdata_reg <= SysWData;
        be_reg    <= SysByteEn;
        err_reg   <= oor_now;
      end
      if (load_rdata) begin
        rdata_reg <= oor_now ? 32'd0 : rd_word;
      end
    end
  end

  // One byte-wide array per lane so each byte enable is a plain write enable.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    // Commit this lane on the edge leaving RESP; the array is never reset.
    always_ff @(posedge clk) begin
      if (do_write && be_reg[gi]) begin
        lane_mem[idx_reg] <= wdata_reg[gi*8 +: 8];
      end
    end

    assign rd_word[gi*8 +: 8] = lane_mem[idx_now];
  end

  assign SysRData = rdata_reg;
  assign SysReady = ready_reg;
  assign SysBusy  = (state_reg != IDLE);
`ifdef SYS_RESP_ERR_EN
  assign SysErr   = err_out_reg;
`endif

endmodule

// File: tb/tb_sys_mem_responder.sv
// Bench for sys_mem_responder: two instances (WAIT_CYCLES = 2 and 0) share
// one bus. A request-phase model predicts busy/ready/err/rdata every cycle;
// directed steps pin the model with hand-computed values; then random traffic.
module tb_sys_mem_responder;

  localparam int AW = 10;
`ifdef SYS_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        SysStrobe = 1'b0;
  logic        SysRW = 1'b0;
  logic [31:0] SysAddr = 32'd0;
  logic [31:0] SysWData = 32'd0;
  logic [3:0]  SysByteEn = 4'd0;

  logic [31:0] rdata_o [2];
  logic        ready_o [2];
  logic        busy_o  [2];
  logic        err_o   [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sys_mem_responder #(.DEPTH(1024), .AW(AW), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .SysStrobe(SysStrobe), .SysRW(SysRW),
    .SysAddr(SysAddr), .SysWData(SysWData), .SysByteEn(SysByteEn),
    .SysRData(rdata_o[0]), .SysReady(ready_o[0]),
`ifdef SYS_RESP_ERR_EN
    .SysErr(err_o[0]),
`endif
    .SysBusy(busy_o[0])
  );

  sys_mem_responder #(.DEPTH(1024), .AW(AW), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .SysStrobe(SysStrobe), .SysRW(SysRW),
    .SysAddr(SysAddr), .SysWData(SysWData), .SysByteEn(SysByteEn),
    .SysRData(rdata_o[1]), .SysReady(ready_o[1]),
`ifdef SYS_RESP_ERR_EN
    .SysErr(err_o[1]),
`endif
    .SysBusy(busy_o[1])
  );

`ifndef SYS_RESP_ERR_EN
  assign err_o[0] = 1'b0;
  assign err_o[1] = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: a request is "k" edges old. Busy while k <= W, ready at
  // k == W+1, a new accept possible once k reaches W+2 (spacing W+2).
  int          wv [2] = '{2, 0};
  bit          act [2] = '{1'b0, 1'b0};
  int          k [2];
  bit          p_rw [2];
  bit          p_err [2];
  int          p_idx [2];
  logic [31:0] p_wd [2];
  logic [3:0]  p_be [2];
  logic [31:0] mm [2][1024];
  bit          known [2][1024];
  logic [31:0] rd_hold [2] = '{32'd0, 32'd0};
  bit          rd_known [2] = '{1'b0, 1'b0};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        act[m]      = 1'b0;
        rd_hold[m]  = 32'd0;
        rd_known[m] = 1'b1;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (act[m]) begin
          k[m]++;
          if (k[m] == wv[m] + 1 && !p_rw[m] && !p_err[m]) begin
            for (int l = 0; l < 4; l++)
              if (p_be[m][l]) mm[m][p_idx[m]][l*8 +: 8] = p_wd[m][l*8 +: 8];
            known[m][p_idx[m]] = known[m][p_idx[m]] || (p_be[m] == 4'hF);
          end
          if (k[m] == wv[m] + 2) act[m] = 1'b0;
        end
        if (!act[m] && SysStrobe) begin
          act[m]   = 1'b1;
          k[m]     = 0;
          p_rw[m]  = SysRW;
          p_idx[m] = int'(SysAddr[AW+1:2]);
          p_wd[m]  = SysWData;
          p_be[m]  = SysByteEn;
          p_err[m] = ERR_EN && (SysAddr[31:AW+2] != 0);
        end
        if (act[m] && k[m] == wv[m] && p_rw[m]) begin
          rd_hold[m]  = p_err[m] ? 32'd0 : mm[m][p_idx[m]];
          rd_known[m] = p_err[m] || known[m][p_idx[m]];
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      bit exp_busy, exp_ready;
      exp_busy  = act[m] && (k[m] <= wv[m]);
      exp_ready = act[m] && (k[m] == wv[m] + 1);
      chk(m == 0 ? "busy_w2" : "busy_w0", 32'(busy_o[m]), 32'(exp_busy));
      chk(m == 0 ? "ready_w2" : "ready_w0", 32'(ready_o[m]), 32'(exp_ready));
      if (rd_known[m])
        chk(m == 0 ? "rdata_w2" : "rdata_w0", rdata_o[m], rd_hold[m]);
      if (ERR_EN)
        chk(m == 0 ? "err_w2" : "err_w0", 32'(err_o[m]), 32'(exp_ready && p_err[m]));
    end
  end

  // ---------------- directed driver ----------------
  logic [31:0] r_rd [2];
  int          r_lat [2];
  int          r_busy [2];
  logic        r_err [2];

  // Issue one request, then record per instance the number of edges from the
  // accept edge to SysReady, the data/err seen with it, and busy cycles.
  task automatic req(input bit rw, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    @(negedge clk);
    SysStrobe = 1'b1; SysRW = rw; SysAddr = a; SysWData = wd; SysByteEn = be;
    @(posedge clk);
    @(negedge clk);
    SysStrobe = 1'b0; SysRW = 1'($urandom); SysAddr = $urandom;
    SysWData = $urandom; SysByteEn = 4'($urandom);
    for (int m = 0; m < 2; m++) begin
      r_lat[m] = -1; r_busy[m] = 0; r_rd[m] = 32'hx; r_err[m] = 1'bx;
    end
    for (int i = 0; i < 20; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (busy_o[m]) r_busy[m]++;
        if (ready_o[m] && r_lat[m] < 0) begin
          r_lat[m] = i; r_rd[m] = rdata_o[m]; r_err[m] = err_o[m];
        end
      end
      if (r_lat[0] >= 0 && r_lat[1] >= 0) break;
      @(negedge clk);
    end
  endtask

  int pulses [2];

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy_o[0]), 32'd0);
    chk("reset_ready", 32'(ready_o[0]), 32'd0);
    chk("reset_rdata", rdata_o[0], 32'd0);
    rst = 1'b1;

    // Full write then read-back; latency 3 edges for W=2, 1 edge for W=0.
    req(1'b0, 32'h10, 32'hDEADBEEF, 4'hF);
    chk("wr_lat_w2", 32'(r_lat[0]), 32'd3);
    chk("wr_lat_w0", 32'(r_lat[1]), 32'd1);
    req(1'b1, 32'h10, 32'h0, 4'h0);
    chk("rd_lat_w2", 32'(r_lat[0]), 32'd3);
    chk("rd_data_w2", r_rd[0], 32'hDEADBEEF);
    chk("rd_lat_w0", 32'(r_lat[1]), 32'd1);
    chk("rd_data_w0", r_rd[1], 32'hDEADBEEF);
    chk("busy_cycles_w2", 32'(r_busy[0]), 32'd3);
    chk("busy_cycles_w0", 32'(r_busy[1]), 32'd1);

    // Byte-enable merge.
    req(1'b0, 32'h20, 32'h11223344, 4'hF);
    req(1'b0, 32'h22, 32'hAABBCCDD, 4'b0101);
    req(1'b1, 32'h21, 32'h0, 4'h0);
    chk("be_merge_w2", r_rd[0], 32'h11BB33DD);
    chk("be_merge_w0", r_rd[1], 32'h11BB33DD);

    // Strobe held for 4 edges: W=2 accepts once, W=0 re-accepts once.
    @(negedge clk);
    SysStrobe = 1'b1; SysRW = 1'b1; SysAddr = 32'h10;
    pulses = '{0, 0};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) if (ready_o[m]) pulses[m]++;
      if (i == 3) SysStrobe = 1'b0;
    end
    chk("hold_pulses_w2", 32'(pulses[0]), 32'd1);
    chk("hold_pulses_w0", 32'(pulses[1]), 32'd2);

    // Asynchronous reset during WAIT aborts the write.
    req(1'b0, 32'h30, 32'h0, 4'hF);
    @(negedge clk);
    SysStrobe = 1'b1; SysRW = 1'b0; SysAddr = 32'h30; SysWData = 32'hFFFFFFFF; SysByteEn = 4'hF;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("arst_busy_w2", 32'(busy_o[0]), 32'd0);
    chk("arst_ready_w2", 32'(ready_o[0]), 32'd0);
    chk("arst_rdata_w2", rdata_o[0], 32'd0);
    chk("arst_busy_w0", 32'(busy_o[1]), 32'd0);
    @(negedge clk);
    SysStrobe = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req(1'b1, 32'h30, 32'h0, 4'h0);
    chk("abort_rd_w2", r_rd[0], 32'h0);
    chk("abort_rd_w0", r_rd[1], 32'h0);

    // Address above the array: wraps, or errors with the feature enabled.
    req(1'b0, 32'h0, 32'h5A5A1234, 4'hF);
    req(1'b1, 32'h1000, 32'h0, 4'h0);
    chk("high_rd_lat_w2", 32'(r_lat[0]), 32'd3);
    if (ERR_EN) begin
      chk("oor_rdata", r_rd[0], 32'h0);
      chk("oor_err", 32'(r_err[0]), 32'd1);
    end else begin
      chk("wrap_rdata", r_rd[0], 32'h5A5A1234);
    end
    req(1'b0, 32'h1000, 32'hFFFFFFFF, 4'hF);
    req(1'b1, 32'h0, 32'h0, 4'h0);
    chk("high_wr_effect", r_rd[0], ERR_EN ? 32'h5A5A1234 : 32'hFFFFFFFF);

    // Random traffic; the compare process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      SysStrobe = ($urandom_range(0, 2) == 0);
      SysRW     = 1'($urandom);
      SysAddr   = (($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFFF000) : 32'h0)
                | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      SysWData  = $urandom;
      SysByteEn = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
    end
    SysStrobe = 1'b0;
    repeat (6) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
